// File: rtl/redmule_exp_sched.sv
// redmule_exp_sched: pairs X shared exponents with W exponent vectors for the
// datapath, popping one W vector every cfg_w_period X exponents.
`default_nettype none

module redmule_exp_sched #(
  parameter int XEXP_WIDTH = 8,
  parameter int WEXP_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  cfg_x_total_i,
  input  logic [CNT_WIDTH-1:0]  cfg_w_period_i,
  input  logic                  x_valid_i,
  input  logic [XEXP_WIDTH-1:0] x_exp_i,
  output logic                  x_consume_o,
  input  logic                  w_valid_i,
  input  logic [WEXP_WIDTH-1:0] w_exp_i,
  output logic                  w_consume_o,
  output logic                  scale_valid_o,
  input  logic                  scale_ready_i,
  output logic [XEXP_WIDTH-1:0] scale_x_o,
  output logic [WEXP_WIDTH-1:0] scale_w_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CNT_WIDTH-1:0] x_total;
  logic [CNT_WIDTH-1:0] w_period;
  logic [CNT_WIDTH-1:0] x_cnt;
  logic [CNT_WIDTH-1:0] w_cnt;
  logic                 in_run;
  logic                 handshake;
  logic                 last_x;
  logic                 w_wrap;
  logic                 start_ok;
  logic                 stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = (cfg_x_total_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (handshake && last_x) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear_i) begin
      state_next = IDLE;
    end
  end

  always_comb begin
    in_run        = (state == RUN);
    scale_valid_o = in_run & x_valid_i & w_valid_i;
    handshake     = scale_valid_o & scale_ready_i;
    last_x        = (x_cnt == x_total - CNT_ONE);
    w_wrap        = (w_cnt == w_period - CNT_ONE);
    x_consume_o   = handshake;
    // The final X of a job also pops W so a partially used vector never lingers.
    w_consume_o   = handshake & (w_wrap | last_x);
    busy_o        = (state != IDLE);
    done_o        = (state == DONE);
    scale_x_o     = x_exp_i;
    scale_w_o     = w_exp_i;
    start_ok      = (state == IDLE) & start_i & ~clear_i;
    stall         = in_run & scale_ready_i & ~scale_valid_o;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_total     <= '0;
      w_period    <= '0;
      x_cnt       <= '0;
      w_cnt       <= '0;
      stall_cnt_o <= '0;
    end else if (clear_i) begin
      x_cnt       <= '0;
      w_cnt       <= '0;
      stall_cnt_o <= '0;
    end else if (start_ok) begin
      x_total     <= cfg_x_total_i;
      w_period    <= (cfg_w_period_i == '0) ? CNT_ONE : cfg_w_period_i;
      x_cnt       <= '0;
      w_cnt       <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (handshake) begin
        x_cnt <= x_cnt + CNT_ONE;
        w_cnt <= w_consume_o ? '0 : (w_cnt + CNT_ONE);
      end
      if (stall && (stall_cnt_o != CNT_MAX)) begin
        stall_cnt_o <= stall_cnt_o + CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_redmule_exp_sched.sv
// Directed bench for redmule_exp_sched: job sequencing, W pairing, stalls,
// zero-length jobs, clear priority and mid-job reset.
`default_nettype none

module tb_redmule_exp_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        start;
  logic [15:0] cfg_total;
  logic [15:0] cfg_period;
  logic        x_valid;
  logic [7:0]  x_exp;
  logic        x_consume;
  logic        w_valid;
  logic [31:0] w_exp;
  logic        w_consume;
  logic        scale_valid;
  logic        scale_ready;
  logic [7:0]  scale_x;
  logic [31:0] scale_w;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int xp;
  int wp;
  logic [4:0] wpat;

  redmule_exp_sched #(.XEXP_WIDTH(8), .WEXP_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .start_i       (start),
    .cfg_x_total_i (cfg_total),
    .cfg_w_period_i(cfg_period),
    .x_valid_i     (x_valid),
    .x_exp_i       (x_exp),
    .x_consume_o   (x_consume),
    .w_valid_i     (w_valid),
    .w_exp_i       (w_exp),
    .w_consume_o   (w_consume),
    .scale_valid_o (scale_valid),
    .scale_ready_i (scale_ready),
    .scale_x_o     (scale_x),
    .scale_w_o     (scale_w),
    .busy_o        (busy),
    .done_o        (done),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; start = 1'b0;
    cfg_total = '0; cfg_period = '0;
    x_valid = 1'b1; w_valid = 1'b1; scale_ready = 1'b1;
    x_exp = 8'h3C; w_exp = 32'h0BAD_F00D;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, scale_valid}, 32'd0);
    chk("rst_cons", {30'd0, x_consume, w_consume}, 32'd0);
    chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
    chk("rst_sx", {24'd0, scale_x}, 32'h3C);
    chk("rst_sw", scale_w, 32'h0BAD_F00D);
    #10;
    rst_n = 1'b1;
    tick();

    // total=4, period=2
    x_exp = 8'hA5; w_exp = 32'hDEAD_BEEF;
    cfg_total = 16'd4; cfg_period = 16'd2; start = 1'b1;
    #1;
    chk("t1_idle_valid", {31'd0, scale_valid}, 32'd0);
    chk("t1_idle_cons", {31'd0, x_consume}, 32'd0);
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t1_xcons", {31'd0, x_consume}, 32'd1);
      chk("t1_wcons", {31'd0, w_consume}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t1_done_early", {31'd0, done}, 32'd0);
      tick();
    end
    #1;
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_busy_done", {31'd0, busy}, 32'd1);
    chk("t1_no_cons_done", {30'd0, x_consume, w_consume}, 32'd0);
    chk("t1_sx", {24'd0, scale_x}, 32'hA5);
    chk("t1_sw", scale_w, 32'hDEAD_BEEF);
    tick();
    #1;
    chk("t1_idle_after", {30'd0, busy, done}, 32'd0);

    // total=5, period=2: W pops on handshakes 2,4,5
    cfg_total = 16'd5; cfg_period = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    xp = 0; wp = 0; wpat = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      xp += int'(x_consume);
      wp += int'(w_consume);
      wpat[i] = w_consume;
      tick();
    end
    chk("t2_xpops", xp, 32'd5);
    chk("t2_wpops", wp, 32'd3);
    chk("t2_wpat", {27'd0, wpat}, 32'b11010);
    #1;
    chk("t2_done", {31'd0, done}, 32'd1);
    tick();

    // total=3, period=1, W empty for 3 cycles
    cfg_total = 16'd3; cfg_period = 16'd1; start = 1'b1; w_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_stall_cons", {30'd0, x_consume, w_consume}, 32'd0);
      tick();
    end
    w_valid = 1'b1;
    #1;
    chk("t3_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    xp = 0; wp = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      xp += int'(x_consume);
      wp += int'(w_consume);
      tick();
    end
    chk("t3_xpops", xp, 32'd3);
    chk("t3_wpops", wp, 32'd3);
    #1;
    chk("t3_done", {31'd0, done}, 32'd1);
    tick();
    #1;
    chk("t3_stall_hold", {16'd0, stall_cnt}, 32'd3);

    // total=0
    cfg_total = 16'd0; cfg_period = 16'd2; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("t4_busy", {31'd0, busy}, 32'd1);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_cons", {30'd0, x_consume, w_consume}, 32'd0);
    chk("t4_valid", {31'd0, scale_valid}, 32'd0);
    tick();
    #1;
    chk("t4_idle", {30'd0, busy, done}, 32'd0);

    // period=0 behaves as period=1
    cfg_total = 16'd2; cfg_period = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wp = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      wp += int'(w_consume);
      tick();
    end
    chk("t5_p0_wpops", wp, 32'd2);
    #1;
    chk("t5_done", {31'd0, done}, 32'd1);
    tick();

    // start during RUN ignored, then clear (with start) after 2 of 6 handshakes
    cfg_total = 16'd6; cfg_period = 16'd2; start = 1'b1;
    tick();
    w_valid = 1'b0;
    #1;
    chk("t6_stall_cons", {31'd0, x_consume}, 32'd0);
    tick();
    start = 1'b0; w_valid = 1'b1;
    #1;
    chk("t6_start_ignored", {16'd0, stall_cnt}, 32'd1);
    chk("t6_hs1", {31'd0, x_consume}, 32'd1);
    tick();
    #1;
    chk("t6_hs2", {31'd0, x_consume}, 32'd1);
    tick();
    clear = 1'b1; start = 1'b1; scale_ready = 1'b0;
    tick();
    clear = 1'b0; start = 1'b0; scale_ready = 1'b1;
    #1;
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_stall_zero", {16'd0, stall_cnt}, 32'd0);
    chk("t6_cons", {30'd0, x_consume, w_consume}, 32'd0);
    xp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      xp += int'(done) + int'(busy) + int'(x_consume);
    end
    chk("t6_quiet", xp, 32'd0);

    // reset mid-job
    cfg_total = 16'd4; cfg_period = 16'd1; start = 1'b1; w_valid = 1'b0;
    tick();
    start = 1'b0;
    #1;
    chk("t7_stall_pre", {31'd0, x_consume}, 32'd0);
    tick();
    w_valid = 1'b1;
    #1;
    chk("t7_hs", {31'd0, x_consume}, 32'd1);
    chk("t7_stall1", {16'd0, stall_cnt}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", {31'd0, busy}, 32'd0);
    chk("t7_valid", {31'd0, scale_valid}, 32'd0);
    chk("t7_cons", {30'd0, x_consume, w_consume}, 32'd0);
    chk("t7_done", {31'd0, done}, 32'd0);
    chk("t7_stall", {16'd0, stall_cnt}, 32'd0);
    chk("t7_sx", {24'd0, scale_x}, {24'd0, x_exp});
    tick();
    rst_n = 1'b1;
    xp = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      xp += int'(done) + int'(busy) + int'(x_consume) + int'(w_consume);
    end
    chk("t7_after_release", xp, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
